// File: rtl/mem_stage.sv
// mem_stage: load/store stage with a single in-flight memory transaction and
// a one-entry registered output toward writeback.
// Optional feature: define MEM_STAGE_MISALIGN_CHECK_EN to trap misaligned
// loads/stores locally (no memory request, lower_misalign=1).
module mem_stage (
   input  logic        clock,
   input  logic        reset,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [63:0] pc,
   input  logic [5:0]  prd,
   input  logic        need_to_wb,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        is_unsigned,
   input  logic [3:0]  ls_size,
   input  logic [63:0] ls_address,
   input  logic [63:0] store_data,
   input  logic [63:0] result,
   input  logic        redirect_flush,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [63:0] mem_req_addr,
   output logic        mem_req_wen,
   output logic [63:0] mem_req_wdata,
   output logic [7:0]  mem_req_wmask,
   input  logic        mem_resp_valid,
   input  logic [63:0] mem_resp_rdata,
   output logic        lower_instr_valid,
   input  logic        lower_instr_ready,
   output logic [63:0] lower_pc,
   output logic [5:0]  lower_prd,
   output logic        lower_need_to_wb,
   output logic [63:0] lower_opload_read_data_wb,
   output logic        lower_misalign
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

   state_t      state;
   logic        kill;

   // Fields of the memory op in flight
   logic [63:0] op_pc;
   logic [5:0]  op_prd;
   logic        op_need_to_wb;
   logic        op_is_load;
   logic        op_is_unsigned;
   logic [3:0]  op_size;
   logic [2:0]  op_offset;
   logic [63:0] op_rdata;

   logic        slot_free;
   logic        is_mem;
   logic        misaligned;
   logic        mis_op;
   logic        accept;
   logic        accept_simple;
   logic        accept_mem;
   logic        out_fire;
   logic [7:0]  size_mask;
   logic [7:0]  req_wmask;
   logic [63:0] req_wdata;
   logic [63:0] shifted;
   logic [63:0] load_data;

   assign slot_free   = ~lower_instr_valid | lower_instr_ready;
   assign instr_ready = (state == IDLE) & slot_free & ~reset;
   assign is_mem      = is_load | is_store;

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
   assign misaligned = (ls_size[1] & ls_address[0])
                     | (ls_size[2] & (|ls_address[1:0]))
                     | (ls_size[3] & (|ls_address[2:0]));
`else
   assign misaligned = 1'b0;
`endif

   assign mis_op        = is_mem & misaligned;
   // Flush wins over a same-cycle accept
   assign accept        = instr_valid & instr_ready & ~redirect_flush;
   assign accept_simple = accept & (~is_mem | mis_op);
   assign accept_mem    = accept & is_mem & ~mis_op;
   assign out_fire      = (state == OUT) & slot_free & ~redirect_flush;

   // Byte-lane mask and data alignment for the outgoing store
   always_comb begin
      if (ls_size[0])      size_mask = 8'h01;
      else if (ls_size[1]) size_mask = 8'h03;
      else if (ls_size[2]) size_mask = 8'h0F;
      else                 size_mask = 8'hFF;
      req_wmask = size_mask << ls_address[2:0];
      req_wdata = store_data << {ls_address[2:0], 3'b000};
   end

   // Extract and extend the loaded value from the aligned doubleword
   always_comb begin
      shifted = op_rdata >> {op_offset, 3'b000};
      if (op_size[0])
         load_data = op_is_unsigned ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
      else if (op_size[1])
         load_data = op_is_unsigned ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      else if (op_size[2])
         load_data = op_is_unsigned ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      else
         load_data = shifted;
   end

   // Transaction FSM with registered memory request
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         kill           <= 1'b0;
         mem_req_valid  <= 1'b0;
         mem_req_addr   <= '0;
         mem_req_wen    <= 1'b0;
         mem_req_wdata  <= '0;
         mem_req_wmask  <= '0;
         op_pc          <= '0;
         op_prd         <= '0;
         op_need_to_wb  <= 1'b0;
         op_is_load     <= 1'b0;
         op_is_unsigned <= 1'b0;
         op_size        <= '0;
         op_offset      <= '0;
         op_rdata       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept_mem) begin
                  state          <= REQ;
                  mem_req_valid  <= 1'b1;
                  mem_req_addr   <= {ls_address[63:3], 3'b000};
                  mem_req_wen    <= is_store;
                  mem_req_wdata  <= req_wdata;
                  mem_req_wmask  <= is_store ? req_wmask : 8'h00;
                  op_pc          <= pc;
                  op_prd         <= prd;
                  op_need_to_wb  <= need_to_wb;
                  op_is_load     <= is_load;
                  op_is_unsigned <= is_unsigned;
                  op_size        <= ls_size;
                  op_offset      <= ls_address[2:0];
               end
            end
            REQ: begin
               if (redirect_flush) begin
                  state         <= IDLE;
                  mem_req_valid <= 1'b0;
               end else if (mem_req_ready) begin
                  state         <= WAIT;
                  mem_req_valid <= 1'b0;
               end
            end
            WAIT: begin
               // A flushed op still owns the bus until its response drains
               if (mem_resp_valid) begin
                  kill <= 1'b0;
                  if (kill | redirect_flush) begin
                     state <= IDLE;
                  end else begin
                     state    <= OUT;
                     op_rdata <= mem_resp_rdata;
                  end
               end else if (redirect_flush) begin
                  kill <= 1'b1;
               end
            end
            OUT: begin
               if (redirect_flush | slot_free) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // One-entry output register toward writeback
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lower_instr_valid         <= 1'b0;
         lower_pc                  <= '0;
         lower_prd                 <= '0;
         lower_need_to_wb          <= 1'b0;
         lower_opload_read_data_wb <= '0;
         lower_misalign            <= 1'b0;
      end else if (redirect_flush) begin
         lower_instr_valid <= 1'b0;
      end else if (accept_simple) begin
         lower_instr_valid         <= 1'b1;
         lower_pc                  <= pc;
         lower_prd                 <= prd;
         lower_need_to_wb          <= mis_op ? 1'b0 : need_to_wb;
         lower_opload_read_data_wb <= mis_op ? ls_address : result;
         lower_misalign            <= mis_op;
      end else if (out_fire) begin
         lower_instr_valid         <= 1'b1;
         lower_pc                  <= op_pc;
         lower_prd                 <= op_prd;
         lower_need_to_wb          <= op_need_to_wb;
         lower_opload_read_data_wb <= op_is_load ? load_data : 64'h0;
         lower_misalign            <= 1'b0;
      end else if (lower_instr_ready) begin
         lower_instr_valid <= 1'b0;
      end
   end

endmodule
